// File: rtl/edac_decode_4bit_pipe_pkg.sv
// Shared EDAC definitions: syndrome range limit and the CRC-4 long division used by the
// paired encoder, so both ends compute the check field identically.
package edac_decode_4bit_pipe_pkg;

  localparam int CW_W        = 12;
  localparam int PAD_W       = 4;
  localparam int S_MAX_VALID = 12;

  function automatic logic [3:0] crc4(input logic [3:0] data, input logic [3:0] poly);
    logic [7:0] r;
    logic [7:0] p;
    r = {data, 4'b0000};
    p = {poly, 4'b0000};
    for (int j = 0; j < 4; j++) begin
      if (r[7-j]) r = r ^ p;
      p = p >> 1;
    end
    return r[3:0];
  endfunction

endpackage

// File: rtl/edac_decode_4bit_pipe_syndrome_correct.sv
// Combinational Hamming(12,8) check: syndrome, single-bit correction, data byte extraction.
// Syndromes above S_MAX_VALID or a non-zero pad leave the word untouched and flag uncorr.
module edac_syndrome_correct
  import edac_decode_4bit_pipe_pkg::*;
(
  input  logic [CW_W-1:0] cw,
  input  logic            pad_err,
  output logic [7:0]      dbyte,
  output logic            corr,
  output logic            uncorr
);

  logic [3:0]      syn;
  logic [CW_W-1:0] fixed;

  always_comb begin
    syn = '0;
    for (int i = 0; i < CW_W; i++) begin
      if (cw[i]) syn = syn ^ 4'(i + 1);
    end
  end

  always_comb begin
    fixed  = cw;
    corr   = 1'b0;
    uncorr = 1'b0;
    dbyte  = '0;
    if (pad_err || (syn > 4'(S_MAX_VALID))) begin
      uncorr = 1'b1;
    end else if (syn != 4'd0) begin
      fixed[syn - 4'd1] = ~cw[syn - 4'd1];
      corr              = 1'b1;
    end
    // data bits live at the non-power-of-two positions
    dbyte = {fixed[11:8], fixed[6:4], fixed[2]};
  end

endmodule

// File: rtl/edac_decode_4bit_pipe.sv
// EDAC receive stage: correct, CRC recheck, 2-cycle valid/ready pipeline, in_ready follows out_ready.
// EDAC_ERR_CNT_EN adds saturating corrected/uncorrectable counters; otherwise they read 0.
module edac_decode_4bit_pipe
  import edac_decode_4bit_pipe_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic [3:0]       crc_poly,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_corr,
  output logic             out_crc_err,
  output logic             out_uncorr,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  logic       s1_valid;
  logic [7:0] s1_byte;
  logic [3:0] s1_poly;
  logic       s1_corr;
  logic       s1_uncorr;

  logic       s2_free;
  logic [7:0] sc_byte;
  logic       sc_corr;
  logic       sc_uncorr;
  logic [3:0] crc_calc;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign crc_calc = crc4(s1_byte[7:4], s1_poly);

  edac_syndrome_correct u_sc (
    .cw      (in_data[CW_W-1:0]),
    .pad_err (in_data[15:12] != 4'(0)),
    .dbyte   (sc_byte),
    .corr    (sc_corr),
    .uncorr  (sc_uncorr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_byte   <= '0;
      s1_poly   <= '0;
      s1_corr   <= 1'b0;
      s1_uncorr <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_byte   <= sc_byte;
        s1_poly   <= crc_poly;
        s1_corr   <= sc_corr;
        s1_uncorr <= sc_uncorr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_corr    <= 1'b0;
      out_crc_err <= 1'b0;
      out_uncorr  <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= s1_byte[7:4];
        out_corr    <= s1_corr;
        out_uncorr  <= s1_uncorr;
        out_crc_err <= (crc_calc != s1_byte[3:0]);
      end
    end
  end

`ifdef EDAC_ERR_CNT_EN
  logic fire;
  assign fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (fire) begin
      if (out_corr && (corr_cnt != '1))
        corr_cnt <= corr_cnt + CNT_W'(1);
      if ((out_uncorr || out_crc_err) && (uncorr_cnt != '1))
        uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign corr_cnt   = '0;
  assign uncorr_cnt = '0;
`endif

endmodule

// File: tb/tb_edac_decode_4bit_pipe.sv
// Directed bench for edac_decode_4bit_pipe: known encoded words, backpressure stream,
// counter saturation/clear and mid-stream reset.
module tb_edac_decode_4bit_pipe;

`ifdef EDAC_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = '0;
  logic [3:0]       crc_poly = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [3:0]       out_data;
  logic             out_corr;
  logic             out_crc_err;
  logic             out_uncorr;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  int total = 0;
  int bad   = 0;

  edac_decode_4bit_pipe #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .crc_poly    (crc_poly),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_corr    (out_corr),
    .out_crc_err (out_crc_err),
    .out_uncorr  (out_uncorr),
    .clr_cnt     (clr_cnt),
    .corr_cnt    (corr_cnt),
    .uncorr_cnt  (uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Single word, no backpressure; optional clr_cnt coincident with its delivery.
  task automatic one_word(input string tag, input logic [15:0] w, input logic [3:0] ed,
                          input logic ec, input logic ee, input logic eu, input logic clr);
    @(negedge clk);
    in_valid = 1'b1; in_data = w; crc_poly = 4'b1011; out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    #1 chk({tag, "_lat1_valid"}, 32'(out_valid), 0);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_corr"}, 32'(out_corr), 32'(ec));
    chk({tag, "_crc_err"}, 32'(out_crc_err), 32'(ee));
    chk({tag, "_uncorr"}, 32'(out_uncorr), 32'(eu));
    clr_cnt = clr;
    @(negedge clk);
    clr_cnt = 1'b0;
    #1 chk({tag, "_drained"}, 32'(out_valid), 0);
  endtask

  logic [15:0] bp_w [4] = '{16'h01B2, 16'h0549, 16'h09B3, 16'h0548};
  logic [3:0]  bp_d [4] = '{4'h1, 4'h5, 4'h9, 4'h5};

  initial begin
    int  sent;
    int  got;
    logic stalled;
    logic [3:0] held;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_flags", 32'({out_corr, out_crc_err, out_uncorr}), 0);
    chk("rst_corr_cnt", 32'(corr_cnt), 0);
    chk("rst_uncorr_cnt", 32'(uncorr_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    //          tag       word      data  corr crc  unc  clr
    one_word("clean",  16'h01B2, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    one_word("single", 16'h0192, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    one_word("double", 16'h01B1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0);
    one_word("syn13",  16'h09B3, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0);
    one_word("pad",    16'h81B2, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    one_word("s1fix",  16'h0548, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);

    #1;
    chk("cnt_corr_a", 32'(corr_cnt), CNT_ON ? 3 : 0);
    chk("cnt_uncorr_a", 32'(uncorr_cnt), CNT_ON ? 3 : 0);

    one_word("clrword", 16'h0192, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("cnt_corr_clr", 32'(corr_cnt), 0);
    chk("cnt_uncorr_clr", 32'(uncorr_cnt), 0);

    for (int k = 0; k < 5; k++)
      one_word("sat", 16'h0192, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("cnt_corr_sat", 32'(corr_cnt), CNT_ON ? 3 : 0);
    chk("cnt_uncorr_sat", 32'(uncorr_cnt), 0);

    // backpressure stream: out_ready low for cycles 2..4
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 4);
      crc_poly  = 4'b1011;
      if (sent < 4) begin
        in_valid = 1'b1; in_data = bp_w[sent];
      end else begin
        in_valid = 1'b0; in_data = '0;
      end
      #1;
      if (stalled) chk("bp_hold", 32'(out_data), 32'(held));
      if (c == 2) chk("bp_in_ready_low", 32'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (got < 4) chk($sformatf("bp_order%0d", got), 32'(out_data), 32'(bp_d[got]));
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_sent", 32'(sent), 4);
    chk("bp_recv", 32'(got), 4);
    chk("bp_cnt_uncorr", 32'(uncorr_cnt), CNT_ON ? 1 : 0);

    // reset with both stages full
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h01B2;
    @(negedge clk);
    in_data = 16'h0549;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    #1 chk("mid_pre_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_cnt", 32'(corr_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk($sformatf("mid_no_out%0d", k), 32'(out_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
